uart_frame_loader: RTL and testbench

//   Sequences the byte stream from the UART receiver into image memory.

---
 rtl/uart_frame_loader.sv | 245 ++++++++++++++++++++++++
 tb/tb_uart_frame_loader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_loader.sv
// rtl/uart_frame_loader.sv - UART byte stream to image memory frame loader
//
// Parses a frame (MAGIC, width, height, width*height pixels) arriving as one
// byte per rising edge of rx_ready. Pixels are written row-major from
// address 0. The finished frame is held until frame_ack. Zero-dimension,
// oversize and stalled frames are reported through err/err_code.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   When defined, a trailing checksum byte (XOR of width, height and all
//   pixels) is expected after the last pixel. A mismatch reports code 11.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rx_data, rx_ready   receiver byte and ready level
//   mem_addr/wdata/we   pixel write port, one cycle after the byte strobe
//   img_width/height    header dimensions, held until the next header
//   frame_valid         complete frame in memory, held until frame_ack
//   frame_ack           encoder has consumed the frame
//   busy                frame in progress
//   err, err_code       one-cycle error pulse and cause of the last error

module uart_frame_loader #(
  parameter int          ADDR_W      = 12,
  parameter logic [7:0]  MAGIC       = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic [7:0]        img_width,
  output logic [7:0]        img_height,
  output logic              frame_valid,
  input  logic              frame_ack,
  output logic              busy,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int          TO_W     = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [16:0] CAPACITY = 17'd1 << ADDR_W;

  localparam logic [1:0] E_ZERO    = 2'b00;
  localparam logic [1:0] E_OVERSZ  = 2'b01;
  localparam logic [1:0] E_TIMEOUT = 2'b10;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [1:0] E_CSUM    = 2'b11;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_WIDTH,
    S_HEIGHT,
    S_PIXELS,
    S_DONE,
    S_ERR
`ifdef LOADER_CHECKSUM_EN
    , S_CHECK
`endif
  } state_t;

  state_t state_q, state_d;

  logic              rx_ready_q;
  logic              stb;
  logic [ADDR_W-1:0] pix_cnt;
  logic [15:0]       pix_total;
  logic [15:0]       dim_prod;
  logic [TO_W-1:0]   idle_cnt;
  logic              last_pix;
  logic              expire;
  logic [1:0]        err_code_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  // rx_ready_q resets high so a ready level already present at reset
  // release is not mistaken for a new byte.
  assign stb      = rx_ready & ~rx_ready_q;
  assign dim_prod = 16'(img_width) * 16'(rx_data);
  assign last_pix = (32'(pix_cnt) == (32'(pix_total) - 32'd1));

  // idle_cnt reads k-1 in the k-th cycle after a strobe; firing two short of
  // the limit puts the err pulse exactly TIMEOUT_CYC cycles after the strobe.
  assign expire = (TIMEOUT_CYC != 0) && ((32'(idle_cnt) + 32'd2) >= TIMEOUT_CYC);

  assign frame_valid = (state_q == S_DONE);
  assign err         = (state_q == S_ERR);
`ifdef LOADER_CHECKSUM_EN
  assign busy = (state_q == S_WIDTH) || (state_q == S_HEIGHT) ||
                (state_q == S_PIXELS) || (state_q == S_CHECK);
`else
  assign busy = (state_q == S_WIDTH) || (state_q == S_HEIGHT) ||
                (state_q == S_PIXELS);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A strobe always takes priority over an expiring timeout.
  always_comb begin
    state_d    = state_q;
    err_code_d = err_code;
    unique case (state_q)
      S_IDLE: begin
        if (stb && (rx_data == MAGIC)) state_d = S_WIDTH;
      end
      S_WIDTH: begin
        if (stb) begin
          state_d = S_HEIGHT;
        end else if (expire) begin
          state_d    = S_ERR;
          err_code_d = E_TIMEOUT;
        end
      end
      S_HEIGHT: begin
        if (stb) begin
          if ((img_width == 8'd0) || (rx_data == 8'd0)) begin
            state_d    = S_ERR;
            err_code_d = E_ZERO;
          end else if ({1'b0, dim_prod} > CAPACITY) begin
            state_d    = S_ERR;
            err_code_d = E_OVERSZ;
          end else begin
            state_d = S_PIXELS;
          end
        end else if (expire) begin
          state_d    = S_ERR;
          err_code_d = E_TIMEOUT;
        end
      end
      S_PIXELS: begin
        if (stb) begin
          if (last_pix) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = S_CHECK;
`else
            state_d = S_DONE;
`endif
          end
        end else if (expire) begin
          state_d    = S_ERR;
          err_code_d = E_TIMEOUT;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (stb) begin
          if (rx_data == csum) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_ERR;
            err_code_d = E_CSUM;
          end
        end else if (expire) begin
          state_d    = S_ERR;
          err_code_d = E_TIMEOUT;
        end
      end
`endif
      S_DONE: begin
        if (frame_ack) state_d = S_IDLE;
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ready_q <= 1'b1;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      img_width  <= '0;
      img_height <= '0;
      err_code   <= '0;
      pix_cnt    <= '0;
      pix_total  <= '0;
      idle_cnt   <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      rx_ready_q <= rx_ready;
      err_code   <= err_code_d;
      mem_we     <= 1'b0;

      if (stb) begin
        idle_cnt <= '0;
      end else if (busy && (TIMEOUT_CYC != 0)) begin
        idle_cnt <= idle_cnt + TO_W'(1);
      end

      if (stb) begin
        unique case (state_q)
          S_IDLE: begin
`ifdef LOADER_CHECKSUM_EN
            if (rx_data == MAGIC) csum <= '0;
`endif
          end
          S_WIDTH: begin
            img_width <= rx_data;
`ifdef LOADER_CHECKSUM_EN
            csum <= csum ^ rx_data;
`endif
          end
          S_HEIGHT: begin
            img_height <= rx_data;
            pix_total  <= dim_prod;
            pix_cnt    <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum <= csum ^ rx_data;
`endif
          end
          S_PIXELS: begin
            mem_we    <= 1'b1;
            mem_addr  <= pix_cnt;
            mem_wdata <= rx_data;
            // Holding on the last pixel keeps a full-capacity frame from wrapping.
            if (!last_pix) pix_cnt <= pix_cnt + ADDR_W'(1);
`ifdef LOADER_CHECKSUM_EN
            csum <= csum ^ rx_data;
`endif
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_loader.sv
// tb/tb_uart_frame_loader.sv - directed self-checking bench for uart_frame_loader
module tb_uart_frame_loader;

  localparam int ADDR_W = 12;
  localparam int TO     = 50;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_data = 8'hA5;
  logic              rx_ready = 1'b1;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic [7:0]        img_width;
  logic [7:0]        img_height;
  logic              frame_valid;
  logic              frame_ack = 1'b0;
  logic              busy;
  logic              err;
  logic [1:0]        err_code;

  uart_frame_loader #(.ADDR_W(ADDR_W), .MAGIC(8'hA5), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .img_width(img_width), .img_height(img_height), .frame_valid(frame_valid),
    .frame_ack(frame_ack), .busy(busy), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int addr; int data; int cyc; } wr_t;
  wr_t wr_q[$];
  int  err_cyc_q[$];
  int  err_code_q[$];

  always @(negedge clk) begin
    if (mem_we) wr_q.push_back('{int'(mem_addr), int'(mem_wdata), cyc});
    if (err) begin
      err_cyc_q.push_back(cyc);
      err_code_q.push_back(int'(err_code));
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output int sc);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    sc       = cyc;
    @(negedge clk);
    rx_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_bytes(input logic [7:0] bq[$], output int sq[$]);
    int sc;
    sq.delete();
    foreach (bq[i]) begin
      send_byte(bq[i], sc);
      sq.push_back(sc);
    end
  endtask

  task automatic clear_logs();
    wr_q.delete();
    err_cyc_q.delete();
    err_code_q.delete();
  endtask

  task automatic ack_frame();
    @(negedge clk);
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
  endtask

  logic [7:0] bq[$];
  int         sq[$];
  int         sc;
  logic [7:0] exp_d[4];

  initial begin
    // Reset with rx_ready already high: its release must not look like a byte.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(frame_valid), 0);
    check("rst_we", 32'(mem_we), 0);
    check("rst_err", 32'(err), 0);
    check("rst_code", 32'(err_code), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_width", 32'(img_width), 0);
    rx_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("ready_hold_busy", 32'(busy), 0);

    // 1: 2x2 frame
    clear_logs();
    bq = '{8'hA5, 8'h02, 8'h02, 8'h10, 8'h20, 8'h30, 8'h40};
    send_bytes(bq, sq);
    exp_d = '{8'h10, 8'h20, 8'h30, 8'h40};
    check("t1_nwr", wr_q.size(), 4);
    for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
      check("t1_addr", wr_q[i].addr, i);
      check("t1_data", wr_q[i].data, 32'(exp_d[i]));
      check("t1_lat", wr_q[i].cyc, sq[3+i] + 1);
    end
    check("t1_w", 32'(img_width), 2);
    check("t1_h", 32'(img_height), 2);
    check("t1_valid", 32'(frame_valid), 1);
    check("t1_busy", 32'(busy), 0);
    send_byte(8'hA5, sc);
    repeat (4) @(negedge clk);
    check("t1_valid_held", 32'(frame_valid), 1);
    check("t1_done_drop_busy", 32'(busy), 0);
    ack_frame();
    check("t1_valid_after_ack", 32'(frame_valid), 0);
    check("t1_busy_after_ack", 32'(busy), 0);
    check("t1_nerr", err_cyc_q.size(), 0);
    check("t1_nwr_final", wr_q.size(), 4);

    // 2: zero dimension, then 1x1 frame
    clear_logs();
    bq = '{8'hA5, 8'h00, 8'h05};
    send_bytes(bq, sq);
    check("t2_nerr", err_cyc_q.size(), 1);
    if (err_code_q.size() > 0) check("t2_code", err_code_q[0], 0);
    if (err_cyc_q.size() > 0) check("t2_err_cyc", err_cyc_q[0], sq[2] + 1);
    check("t2_nwr", wr_q.size(), 0);
    clear_logs();
    bq = '{8'hA5, 8'h01, 8'h01, 8'h7F};
    send_bytes(bq, sq);
    check("t2b_nwr", wr_q.size(), 1);
    if (wr_q.size() > 0) begin
      check("t2b_addr", wr_q[0].addr, 0);
      check("t2b_data", wr_q[0].data, 32'h7F);
    end
    check("t2b_valid", 32'(frame_valid), 1);
    check("t2b_code_held", 32'(err_code), 0);
    ack_frame();
    check("t2b_valid_ack", 32'(frame_valid), 0);

    // 3: junk in IDLE dropped; oversize 128*64 = 8192 > 4096
    clear_logs();
    bq = '{8'h3C, 8'h55};
    send_bytes(bq, sq);
    check("t3_junk_busy", 32'(busy), 0);
    check("t3_junk_nerr", err_cyc_q.size(), 0);
    bq = '{8'hA5, 8'h80, 8'h40};
    send_bytes(bq, sq);
    check("t3_nerr", err_cyc_q.size(), 1);
    if (err_code_q.size() > 0) check("t3_code", err_code_q[0], 1);
    check("t3_nwr", wr_q.size(), 0);
    check("t3_busy", 32'(busy), 0);

    // 4: 4x4 frame stalls after 3 pixels
    clear_logs();
    bq = '{8'hA5, 8'h04, 8'h04, 8'h01, 8'h02, 8'h03};
    send_bytes(bq, sq);
    repeat (TO + 10) @(negedge clk);
    check("t4_nwr", wr_q.size(), 3);
    check("t4_nerr", err_cyc_q.size(), 1);
    if (err_cyc_q.size() > 0) begin
      check("t4_code", err_code_q[0], 2);
      check("t4_err_cyc", err_cyc_q[0], sq[5] + TO);
    end
    check("t4_valid", 32'(frame_valid), 0);
    check("t4_busy", 32'(busy), 0);

    // 5: reset mid-PIXELS abandons the frame silently
    clear_logs();
    bq = '{8'hA5, 8'h02, 8'h02, 8'h10};
    send_bytes(bq, sq);
    check("t5_busy_pre", 32'(busy), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_busy_post", 32'(busy), 0);
    bq = '{8'h20, 8'h30, 8'h40};
    send_bytes(bq, sq);
    repeat (TO + 5) @(negedge clk);
    check("t5_nwr", wr_q.size(), 1);
    check("t5_nerr", err_cyc_q.size(), 0);
    check("t5_valid", 32'(frame_valid), 0);

`ifdef LOADER_CHECKSUM_EN
    // 6: checksum 01^02^11^22 = 30
    clear_logs();
    bq = '{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h30};
    send_bytes(bq, sq);
    check("t6_valid", 32'(frame_valid), 1);
    check("t6_nerr", err_cyc_q.size(), 0);
    ack_frame();
    clear_logs();
    bq = '{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h31};
    send_bytes(bq, sq);
    check("t6b_valid", 32'(frame_valid), 0);
    check("t6b_nerr", err_cyc_q.size(), 1);
    if (err_code_q.size() > 0) check("t6b_code", err_code_q[0], 3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
